// File: rtl/sram_like_pkg.sv
// Shared encodings for the SRAM-like bus responder: access sizes, FSM states
// and the size/offset to byte-lane mapping.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // All-zero result marks a misaligned or illegal access.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << ofs;
            SIZE_HALF: be = ofs[0] ? 4'b0000 : (ofs[1] ? 4'b1100 : 4'b0011);
            SIZE_WORD: be = (ofs == 2'b00) ? 4'b1111 : 4'b0000;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port; a read of the word being written in the same cycle sees the new bytes.
module byte_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Output register resets to zero; contents of mem are left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'h0;
        end else if (re) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i] && (waddr == raddr)) begin
                    rdata[8*i +: 8] <= wdata[8*i +: 8];
                end else begin
                    rdata[8*i +: 8] <= mem[raddr][8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// Target end of the SRAM-like req/addr_ok/data_ok handshake: one outstanding
// request, fixed LATENCY to the data_ok pulse, byte-masked writes into byte_ram.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        hs;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [AW-1:0] ram_raddr;
    logic        unused_addr_hi;

    // Upper address bits are deliberately ignored: the RAM aliases.
    assign unused_addr_hi = ^addr[31:AW+2];

    assign addr_ok = !rst && (state != ST_WAIT);
    assign hs      = req && addr_ok;
    assign data_ok = !rst && (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (hs) begin
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
        end
    end

    // The read is launched on the edge entering RESP; at LATENCY 1 that is the
    // acceptance edge itself, so the live bus address is used.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = addr_q[AW+1:2];
        if (!rst) begin
            if (LATENCY == 1 && hs) begin
                ram_re    = !wr;
                ram_raddr = addr[AW+1:2];
            end else if (state == ST_WAIT && cnt == 4'd1) begin
                ram_re = !wr_q;
            end
        end
    end

    assign ram_we = (data_ok && wr_q) ? byte_en(size_q, addr_q[1:0]) : 4'b0000;

    byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: one instance at LATENCY 2 and one at
// LATENCY 1, each scenario in its own task with hand-computed expectations.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        req1 = 1'b0, wr1 = 1'b0;
    logic [1:0]  size1 = 2'd0;
    logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
    logic        addr_ok1, data_ok1;
    logic [31:0] rdata1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_like_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    sram_like_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
        .wdata(wdata1), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request on the LATENCY-2 instance and runs through its data_ok cycle.
    task automatic xact(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat,
                        output logic acc);
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        acc = addr_ok;
        step();
        req = 1'b0;
        lat = 1;
        while (!data_ok && lat < 20) begin
            step();
            lat++;
        end
        rd = rdata;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (addr_ok !== 1'b0) begin failures++; $display("FAIL rst_addr_ok got=%b exp=0", addr_ok); end
        checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL rst_data_ok got=%b exp=0", data_ok); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=00000000", rdata); end
        rst = 1'b0;
        #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL rst_release_addr_ok got=%b exp=1", addr_ok); end
        checks++; if (addr_ok1 !== 1'b1) begin failures++; $display("FAIL rst_release_addr_ok1 got=%b exp=1", addr_ok1); end
        step();
    endtask

    task automatic test_read();
        logic [31:0] rd; int lat; logic acc;
        xact(1'b1, 2'd2, 32'h0000_0010, 32'hCAFE_F00D, rd, lat, acc);
        checks++; if (lat !== 2) begin failures++; $display("FAIL wr10_latency got=%0d exp=2", lat); end
        xact(1'b0, 2'd2, 32'h0000_0010, 32'h0, rd, lat, acc);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL rd10_addr_ok got=%b exp=1", acc); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL rd10_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL rd10_data got=%h exp=cafef00d", rd); end
        checks++; if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL rd10_hold got=%h exp=cafef00d", rdata); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; int lat; logic acc;
        xact(1'b1, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF, rd, lat, acc);
        xact(1'b1, 2'd0, 32'h0000_0023, 32'hAA00_0000, rd, lat, acc);
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_keeps_rdata got=%h exp=cafef00d", rd); end
        xact(1'b0, 2'd2, 32'h0000_0020, 32'h0, rd, lat, acc);
        checks++; if (rd !== 32'hAAAD_BEEF) begin failures++; $display("FAIL byte_merge got=%h exp=aaadbeef", rd); end
        xact(1'b1, 2'd1, 32'h0000_0020, 32'h5555_1234, rd, lat, acc);
        xact(1'b0, 2'd2, 32'h0000_0020, 32'h0, rd, lat, acc);
        checks++; if (rd !== 32'hAAAD_1234) begin failures++; $display("FAIL half_merge got=%h exp=aaad1234", rd); end
    endtask

    task automatic test_back_to_back();
        int lat;
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'h1234_5678;
        step();
        req = 1'b0;
        lat = 1;
        while (!data_ok && lat < 20) begin step(); lat++; end
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_wr_latency got=%0d exp=2", lat); end
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL b2b_addr_ok_in_resp got=%b exp=1", addr_ok); end
        req = 1'b1; wr = 1'b0; addr = 32'h40; wdata = 32'h0;
        step();
        req = 1'b0;
        checks++; if (addr_ok !== 1'b0 || data_ok !== 1'b0) begin failures++; $display("FAIL b2b_wait got=%b%b exp=00", addr_ok, data_ok); end
        step();
        checks++; if (data_ok !== 1'b1) begin failures++; $display("FAIL b2b_rd_data_ok got=%b exp=1", data_ok); end
        checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL b2b_rd_data got=%h exp=12345678", rdata); end
        step();
        checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL b2b_single_pulse got=%b exp=0", data_ok); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; int lat; logic acc;
        xact(1'b1, 2'd2, 32'h0000_0050, 32'h0BAD_F00D, rd, lat, acc);
        xact(1'b1, 2'd1, 32'h0000_0051, 32'hFFFF_FFFF, rd, lat, acc);
        checks++; if (lat !== 2) begin failures++; $display("FAIL mis_half_data_ok got=%0d exp=2", lat); end
        xact(1'b1, 2'd2, 32'h0000_0052, 32'hFFFF_FFFF, rd, lat, acc);
        checks++; if (lat !== 2) begin failures++; $display("FAIL mis_word_data_ok got=%0d exp=2", lat); end
        xact(1'b1, 2'd3, 32'h0000_0050, 32'hFFFF_FFFF, rd, lat, acc);
        checks++; if (lat !== 2) begin failures++; $display("FAIL illegal_size_data_ok got=%0d exp=2", lat); end
        xact(1'b0, 2'd2, 32'h0000_0052, 32'h0, rd, lat, acc);
        checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL mis_word_unchanged got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic acc; int pulses;
        xact(1'b1, 2'd2, 32'h0000_0060, 32'h1111_2222, rd, lat, acc);
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h60; wdata = 32'h9999_9999;
        step();
        req = 1'b0;
        checks++; if (addr_ok !== 1'b0) begin failures++; $display("FAIL mid_wait_addr_ok got=%b exp=0", addr_ok); end
        rst = 1'b1;
        step();
        checks++; if (addr_ok !== 1'b0 || data_ok !== 1'b0) begin failures++; $display("FAIL mid_in_rst got=%b%b exp=00", addr_ok, data_ok); end
        rst = 1'b0;
        #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL mid_addr_ok_after_rst got=%b exp=1", addr_ok); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin step(); if (data_ok) pulses++; end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_no_pulse got=%0d exp=0", pulses); end
        // Reset landing in the response cycle itself.
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h60; wdata = 32'h7777_7777;
        step();
        req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL resp_rst_data_ok got=%b exp=0", data_ok); end
        step();
        rst = 1'b0;
        #1;
        xact(1'b0, 2'd2, 32'h0000_0060, 32'h0, rd, lat, acc);
        checks++; if (rd !== 32'h1111_2222) begin failures++; $display("FAIL mid_word_unchanged got=%h exp=11112222", rd); end
    endtask

    task automatic test_latency1();
        logic [31:0] exp_q[$];
        logic        was_rd;
        logic [31:0] addrs [8];
        logic [31:0] wvals [4];
        addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'h0, 32'h4, 32'h8};
        wvals = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
        was_rd = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                checks++; if (data_ok1 !== 1'b1) begin failures++; $display("FAIL l1_data_ok op=%0d got=%b exp=1", k-1, data_ok1); end
                if (was_rd) begin
                    checks++; if (rdata1 !== exp_q[0]) begin failures++; $display("FAIL l1_rdata op=%0d got=%h exp=%h", k-1, rdata1, exp_q[0]); end
                    exp_q.pop_front();
                end
            end
            checks++; if (addr_ok1 !== 1'b1) begin failures++; $display("FAIL l1_addr_ok op=%0d got=%b exp=1", k, addr_ok1); end
            if (k < 8) begin
                req1 = 1'b1; size1 = 2'd2; addr1 = addrs[k];
                wr1 = (k < 4);
                wdata1 = (k < 4) ? wvals[k] : 32'h0;
                was_rd = (k >= 4);
                if (k >= 4) exp_q.push_back(wvals[addrs[k][3:2]]);
            end else begin
                req1 = 1'b0;
            end
            step();
        end
        checks++; if (data_ok1 !== 1'b0) begin failures++; $display("FAIL l1_idle_after got=%b exp=0", data_ok1); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_merge();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
